// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter, frame = start, Nbit data LSB first,
// optional even parity, one stop bit. All outputs registered.
module uart_tx #(
    parameter int Nbit      = 8,
    parameter int baudrate  = 9600,
    parameter int clk_freq  = 50000000,
    parameter int PARITY_EN = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_tx,
    input  logic [Nbit-1:0] DataTx,
    input  logic            clr_tx_flag,
    output logic            SerialDataOut,
    output logic            Tx_busy,
    output logic            Tx_flag
);

    localparam int bit_time      = clk_freq / baudrate;
    localparam int baud_cnt_bits = (bit_time > 1) ? $clog2(bit_time) : 1;
    localparam int bit4count     = (Nbit > 1) ? $clog2(Nbit) : 1;

    localparam logic [baud_cnt_bits-1:0] baud_last =
        baud_cnt_bits'(bit_time - 1);
    localparam logic [bit4count:0] bit_last =
        (bit4count + 1)'(Nbit - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                   state;
    state_t                   state_n;
    logic [Nbit-1:0]          shreg;
    logic [Nbit-1:0]          shreg_n;
    logic [baud_cnt_bits-1:0] baud;
    logic [baud_cnt_bits-1:0] baud_n;
    logic [bit4count:0]       bitcnt;
    logic [bit4count:0]       bitcnt_n;
    logic                     par;
    logic                     par_n;
    logic                     line_n;
    logic                     busy_n;
    logic                     flag_n;
    logic                     bit_end;

    assign bit_end = (baud == baud_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            shreg         <= '0;
            baud          <= '0;
            bitcnt        <= '0;
            par           <= 1'b0;
            SerialDataOut <= 1'b1;
            Tx_busy       <= 1'b0;
            Tx_flag       <= 1'b0;
        end else begin
            state         <= state_n;
            shreg         <= shreg_n;
            baud          <= baud_n;
            bitcnt        <= bitcnt_n;
            par           <= par_n;
            SerialDataOut <= line_n;
            Tx_busy       <= busy_n;
            Tx_flag       <= flag_n;
        end
    end

    // Line value is computed one cycle ahead so it only moves on bit edges
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        baud_n   = baud;
        bitcnt_n = bitcnt;
        par_n    = par;
        line_n   = SerialDataOut;
        busy_n   = Tx_busy;
        flag_n   = clr_tx_flag ? 1'b0 : Tx_flag;

        if (state != IDLE) begin
            baud_n = bit_end ? '0 : baud + 1'b1;
        end

        unique case (state)
            IDLE: begin
                baud_n   = '0;
                bitcnt_n = '0;
                line_n   = 1'b1;
                busy_n   = 1'b0;
                if (start_tx) begin
                    shreg_n = DataTx;
                    par_n   = ^DataTx;
                    state_n = START;
                    line_n  = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    line_n  = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_n  = shreg >> 1;
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == bit_last) begin
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            line_n  = par;
                        end else begin
                            state_n = STOP;
                            line_n  = 1'b1;
                        end
                    end else begin
                        line_n = shreg_n[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    line_n  = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    line_n  = 1'b1;
                    busy_n  = 1'b0;
                    flag_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                line_n  = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks uart_tx without and with parity against a
// bit-sequence reference model and a mid-bit sampling receiver model.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int BT = 10;
    localparam int NB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start_tx;
    logic [1:0] clr_tx_flag;
    logic [7:0] data_tx [2];
    logic [1:0] line;
    logic [1:0] busy;
    logic [1:0] flag;
    bit   [1:0] exp_flag;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .Nbit(NB), .baudrate(100000), .clk_freq(1000000), .PARITY_EN(0)
    ) u_dut0 (
        .clk(clk),
        .reset(reset),
        .start_tx(start_tx[0]),
        .DataTx(data_tx[0]),
        .clr_tx_flag(clr_tx_flag[0]),
        .SerialDataOut(line[0]),
        .Tx_busy(busy[0]),
        .Tx_flag(flag[0])
    );

    uart_tx #(
        .Nbit(NB), .baudrate(100000), .clk_freq(1000000), .PARITY_EN(1)
    ) u_dut1 (
        .clk(clk),
        .reset(reset),
        .start_tx(start_tx[1]),
        .DataTx(data_tx[1]),
        .clr_tx_flag(clr_tx_flag[1]),
        .SerialDataOut(line[1]),
        .Tx_busy(busy[1]),
        .Tx_flag(flag[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected line level k cycles after the accept edge
    function automatic logic ref_bit(input logic [7:0] v, input int pe,
                                     input int k);
        int b;
        b = k / BT;
        if (b == 0) return 1'b0;
        if (b <= NB) return v[b-1];
        if (pe != 0 && b == NB + 1) return ^v;
        return 1'b1;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("idle_line%0d", i), line[i], 1'b1);
                chk($sformatf("idle_busy%0d", i), busy[i], 1'b0);
                chk($sformatf("idle_flag%0d", i), flag[i], exp_flag[i]);
            end
        end
    endtask

    // Called at a negedge; start_tx is sampled on the next rising edge
    task automatic run_frame(input int d, input logic [7:0] v,
                             input bit noise, input int clr_at,
                             input int ign_at);
        int         len;
        int         b;
        logic [7:0] rx;
        logic       rx_start;
        logic       rx_par;
        logic       rx_stop;
        len = (NB + 2 + d) * BT;
        rx = '0;
        rx_start = 1'b1;
        rx_par = 1'b0;
        rx_stop = 1'b0;
        start_tx[d] = 1'b1;
        data_tx[d] = v;
        clr_tx_flag[d] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < len; k++) begin
            chk($sformatf("line%0d_%0d", d, k), line[d], ref_bit(v, d, k));
            chk($sformatf("busy%0d_%0d", d, k), busy[d], 1'b1);
            chk($sformatf("flag%0d_%0d", d, k), flag[d], exp_flag[d]);
            if (k % BT == BT / 2) begin
                b = k / BT;
                if (b == 0) rx_start = line[d];
                else if (b <= NB) rx[b-1] = line[d];
                else if (d != 0 && b == NB + 1) rx_par = line[d];
                else rx_stop = line[d];
            end
            start_tx[d] = 1'b0;
            data_tx[d] = ~v;
            clr_tx_flag[d] = (k == clr_at);
            if (k == ign_at) begin
                start_tx[d] = 1'b1;
                data_tx[d] = 8'hFF;
            end
            if (noise) begin
                data_tx[d] = 8'($urandom);
                if ($urandom_range(0, 7) == 0) start_tx[d] = 1'b1;
                if ($urandom_range(0, 31) == 0) clr_tx_flag[d] = 1'b1;
            end
            if (clr_tx_flag[d]) exp_flag[d] = 1'b0;
            if (k == len - 1) exp_flag[d] = 1'b1;
            @(negedge clk);
        end
        start_tx[d] = 1'b0;
        clr_tx_flag[d] = 1'b0;
        chk($sformatf("end_busy%0d", d), busy[d], 1'b0);
        chk($sformatf("end_line%0d", d), line[d], 1'b1);
        chk($sformatf("end_flag%0d", d), flag[d], 1'b1);
        chk($sformatf("rx_data%0d", d), rx, v);
        chk($sformatf("rx_start%0d", d), rx_start, 1'b0);
        chk($sformatf("rx_stop%0d", d), rx_stop, 1'b1);
        if (d != 0) chk("rx_par", rx_par, ^v);
    endtask

    initial begin
        int         d;
        logic [7:0] v;
        reset = 1'b1;
        start_tx = '0;
        clr_tx_flag = '0;
        data_tx[0] = '0;
        data_tx[1] = '0;
        exp_flag = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_line%0d", i), line[i], 1'b1);
            chk($sformatf("rst_busy%0d", i), busy[i], 1'b0);
            chk($sformatf("rst_flag%0d", i), flag[i], 1'b0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(2);

        run_frame(0, 8'hA5, 1'b0, -1, -1);
        idle(1);
        clr_tx_flag[0] = 1'b1;
        @(negedge clk);
        clr_tx_flag[0] = 1'b0;
        exp_flag[0] = 1'b0;
        chk("clr_flag", flag[0], 1'b0);
        chk("clr_line", line[0], 1'b1);
        idle(1);

        run_frame(1, 8'h07, 1'b0, -1, -1);
        run_frame(1, 8'h03, 1'b0, -1, -1);
        run_frame(0, 8'h55, 1'b0, -1, 29);
        run_frame(0, 8'h0F, 1'b0, -1, -1);
        idle(2);
        run_frame(1, 8'h3C, 1'b0, (NB + 3) * BT - 1, -1);
        idle(2);
        run_frame(0, 8'h00, 1'b0, -1, -1);
        run_frame(0, 8'hFF, 1'b0, -1, -1);
        run_frame(0, 8'h5A, 1'b0, -1, -1);

        start_tx[0] = 1'b1;
        data_tx[0] = 8'hC3;
        @(negedge clk);
        start_tx[0] = 1'b0;
        repeat (44) @(negedge clk);
        chk("mid_busy", busy[0], 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        exp_flag = '0;
        chk("arst_line", line[0], 1'b1);
        chk("arst_busy", busy[0], 1'b0);
        chk("arst_flag0", flag[0], 1'b0);
        chk("arst_flag1", flag[1], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        run_frame(0, 8'h81, 1'b0, -1, -1);

        for (int n = 0; n < 24; n++) begin
            d = int'($urandom_range(0, 1));
            v = 8'($urandom);
            run_frame(d, v, 1'b1,
                      ($urandom_range(0, 3) == 0) ? (NB + 2 + d) * BT - 1 : -1,
                      -1);
            idle(int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
